// File: rtl/id_ex_stage_pkg.sv
// Shared ALU select, ALUOp and funct encodings for the ID/EX stage.
// Imported by id_ex_stage and alu_control.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALUOp/funct to 4-bit ALU select decoder.
// Ports: alu_op, funct in; alu_select out.
import id_ex_stage_pkg::*;

module alu_control (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_select
);

  always_comb begin
    alu_select = ALU_INVALID;
    case (alu_op)
      OP_ADD: alu_select = ALU_ADD;
      OP_SUB: alu_select = ALU_SUB;
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_select = ALU_ADD;
          F_SUB:   alu_select = ALU_SUB;
          F_AND:   alu_select = ALU_AND;
          F_OR:    alu_select = ALU_OR;
          F_SLT:   alu_select = ALU_SLT;
          default: alu_select = ALU_INVALID;
        endcase
      end
      OP_RSVD: alu_select = ALU_INVALID;
      default: alu_select = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode outputs, stall/flush, ALU operands.
// Optional EX/MEM and MEM/WB forwarding ports with ID_EX_FORWARDING_EN.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int bits      = 8,
  parameter int addr_bits = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [bits-1:0]      in_rs_data,
  input  logic [bits-1:0]      in_rt_data,
  input  logic [bits-1:0]      in_imm,
  input  logic [addr_bits-1:0] in_rs_addr,
  input  logic [addr_bits-1:0] in_rt_addr,
  input  logic [addr_bits-1:0] in_rd_addr,
  input  logic [1:0]           in_alu_op,
  input  logic [5:0]           in_funct,
  input  logic                 in_alu_src,
  input  logic                 in_reg_dst,
  input  logic                 in_reg_write,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic                 in_mem_to_reg,
  output logic [bits-1:0]      alu_a,
  output logic [bits-1:0]      alu_b,
  output logic [3:0]           alu_select,
  output logic [bits-1:0]      store_data,
  output logic [addr_bits-1:0] wr_addr,
  output logic                 out_valid,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic [addr_bits-1:0] out_rs_addr,
  output logic [addr_bits-1:0] out_rt_addr
`ifdef ID_EX_FORWARDING_EN
  ,
  input  logic                 exmem_reg_write,
  input  logic [addr_bits-1:0] exmem_wr_addr,
  input  logic [bits-1:0]      exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [addr_bits-1:0] memwb_wr_addr,
  input  logic [bits-1:0]      memwb_result
`endif
);

  logic [3:0] sel_dec;

  alu_control u_alu_control (
    .alu_op     (in_alu_op),
    .funct      (in_funct),
    .alu_select (sel_dec)
  );

  logic                 valid_q, valid_d;
  logic                 rw_q, rw_d;
  logic                 mr_q, mr_d;
  logic                 mw_q, mw_d;
  logic                 m2r_q, m2r_d;
  logic                 src_q, src_d;
  logic [3:0]           sel_q, sel_d;
  logic [bits-1:0]      rs_q, rs_d;
  logic [bits-1:0]      rt_q, rt_d;
  logic [bits-1:0]      imm_q, imm_d;
  logic [addr_bits-1:0] wa_q, wa_d;
  logic [addr_bits-1:0] rsa_q, rsa_d;
  logic [addr_bits-1:0] rta_q, rta_d;
  logic [addr_bits-1:0] wa_sel;

  assign wa_sel = in_reg_dst ? in_rd_addr : in_rt_addr;

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    src_d   = src_q;
    sel_d   = sel_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    wa_d    = wa_q;
    rsa_d   = rsa_q;
    rta_d   = rta_q;
    if (flush || (!stall && !in_valid)) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
      src_d   = 1'b0;
      sel_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      imm_d   = '0;
      wa_d    = '0;
      rsa_d   = '0;
      rta_d   = '0;
    end else if (!stall) begin
      valid_d = 1'b1;
      // r0 is hardwired; never let a write to it reach writeback
      rw_d    = in_reg_write && (wa_sel != '0);
      mr_d    = in_mem_read;
      mw_d    = in_mem_write;
      m2r_d   = in_mem_to_reg;
      src_d   = in_alu_src;
      sel_d   = sel_dec;
      rs_d    = in_rs_data;
      rt_d    = in_rt_data;
      imm_d   = in_imm;
      wa_d    = wa_sel;
      rsa_d   = in_rs_addr;
      rta_d   = in_rt_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      src_q   <= 1'b0;
      sel_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      wa_q    <= '0;
      rsa_q   <= '0;
      rta_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
      src_q   <= src_d;
      sel_q   <= sel_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      wa_q    <= wa_d;
      rsa_q   <= rsa_d;
      rta_q   <= rta_d;
    end
  end

  logic [bits-1:0] rs_op, rt_op;

`ifdef ID_EX_FORWARDING_EN
  logic ex_rs, ex_rt, wb_rs, wb_rt;

  assign ex_rs = exmem_reg_write && (exmem_wr_addr != '0)
              && (exmem_wr_addr == rsa_q);
  assign ex_rt = exmem_reg_write && (exmem_wr_addr != '0)
              && (exmem_wr_addr == rta_q);
  assign wb_rs = memwb_reg_write && (memwb_wr_addr != '0)
              && (memwb_wr_addr == rsa_q);
  assign wb_rt = memwb_reg_write && (memwb_wr_addr != '0)
              && (memwb_wr_addr == rta_q);

  // EX/MEM holds the younger result, so it beats MEM/WB
  always_comb begin
    rs_op = rs_q;
    rt_op = rt_q;
    if (ex_rs)      rs_op = exmem_result;
    else if (wb_rs) rs_op = memwb_result;
    if (ex_rt)      rt_op = exmem_result;
    else if (wb_rt) rt_op = memwb_result;
  end
`else
  assign rs_op = rs_q;
  assign rt_op = rt_q;
`endif

  assign alu_a       = rs_op;
  assign alu_b       = src_q ? imm_q : rt_op;
  assign store_data  = rt_op;
  assign alu_select  = sel_q;
  assign wr_addr     = wa_q;
  assign out_valid   = valid_q;
  assign reg_write   = rw_q;
  assign mem_read    = mr_q;
  assign mem_write   = mw_q;
  assign mem_to_reg  = m2r_q;
  assign out_rs_addr = rsa_q;
  assign out_rt_addr = rta_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors, queued expectations.
// Forwarding vectors are included when ID_EX_FORWARDING_EN is defined.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] sd;
    logic [4:0] wa;
    logic       v;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic [4:0] rsa;
    logic [4:0] rta;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, stall, flush, in_valid;
  logic [7:0] in_rs_data, in_rt_data, in_imm;
  logic [4:0] in_rs_addr, in_rt_addr, in_rd_addr;
  logic [1:0] in_alu_op;
  logic [5:0] in_funct;
  logic       in_alu_src, in_reg_dst, in_reg_write;
  logic       in_mem_read, in_mem_write, in_mem_to_reg;
  logic [7:0] alu_a, alu_b, store_data;
  logic [3:0] alu_select;
  logic [4:0] wr_addr, out_rs_addr, out_rt_addr;
  logic       out_valid, reg_write, mem_read, mem_write, mem_to_reg;
`ifdef ID_EX_FORWARDING_EN
  logic       exmem_reg_write, memwb_reg_write;
  logic [4:0] exmem_wr_addr, memwb_wr_addr;
  logic [7:0] exmem_result, memwb_result;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.bits(8), .addr_bits(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr),
    .in_alu_op(in_alu_op), .in_funct(in_funct),
    .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .store_data(store_data), .wr_addr(wr_addr),
    .out_valid(out_valid), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg),
    .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr)
`ifdef ID_EX_FORWARDING_EN
    ,
    .exmem_reg_write(exmem_reg_write), .exmem_wr_addr(exmem_wr_addr),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_wr_addr(memwb_wr_addr),
    .memwb_result(memwb_result)
`endif
  );

  exp_t  sbq[$];
  string nmq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic exp_t mk(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
    input logic [7:0] sd, input logic [4:0] wa, input logic v,
    input logic rw, input logic mr, input logic mw, input logic m2r,
    input logic [4:0] rsa, input logic [4:0] rta);
    exp_t e;
    e = '{a, b, sel, sd, wa, v, rw, mr, mw, m2r, rsa, rta};
    return e;
  endfunction

  // Monitor: after each rising edge, check the oldest expectation
  initial begin
    exp_t  e, got;
    string n;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n = nmq.pop_front();
        got = {alu_a, alu_b, alu_select, store_data, wr_addr,
               out_valid, reg_write, mem_read, mem_write, mem_to_reg,
               out_rs_addr, out_rt_addr};
        n_chk++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", n, got, e);
        end
      end
    end
  end

  task automatic idle();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0;
    in_alu_op = '0; in_funct = '0; in_alu_src = 1'b0;
    in_reg_dst = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
    in_mem_write = 1'b0; in_mem_to_reg = 1'b0;
`ifdef ID_EX_FORWARDING_EN
    exmem_reg_write = 1'b0; exmem_wr_addr = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_wr_addr = '0; memwb_result = '0;
`endif
  endtask

  task automatic rand_in();
    in_valid = 1'b1;
    stall = 1'($urandom); flush = 1'($urandom);
    in_rs_data = 8'($urandom); in_rt_data = 8'($urandom);
    in_imm = 8'($urandom);
    in_rs_addr = 5'($urandom); in_rt_addr = 5'($urandom);
    in_rd_addr = 5'($urandom);
    in_alu_op = 2'($urandom); in_funct = 6'($urandom);
    in_alu_src = 1'($urandom); in_reg_dst = 1'($urandom);
    in_reg_write = 1'b1; in_mem_read = 1'($urandom);
    in_mem_write = 1'($urandom); in_mem_to_reg = 1'($urandom);
  endtask

  // Inputs are set at a falling edge; the result is due after the next rise
  task automatic cyc(input string n, input exp_t e);
    sbq.push_back(e);
    nmq.push_back(n);
    @(negedge clk);
  endtask

  task automatic rtype_sub();
    idle();
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b100010;
    in_rs_data = 8'h09; in_rt_data = 8'h04; in_imm = 8'h55;
    in_reg_dst = 1'b1; in_rd_addr = 5'd3; in_reg_write = 1'b1;
    in_rs_addr = 5'd1; in_rt_addr = 5'd2;
  endtask

  logic [1:0] t_op  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
  logic [5:0] t_fn  [7] = '{6'h20, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h20, 6'h3F};
  logic [3:0] t_sel [7] = '{4'h2, 4'h0, 4'h1, 4'h7, 4'h6, 4'hF, 4'hF};

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);

    repeat (2) begin
      rand_in(); rst = 1'b0;
      cyc("reset", '0);
    end

    rtype_sub();
    cyc("rtype_sub", mk(8'h09, 8'h04, 4'h6, 8'h04, 5'd3,
                        1, 1, 0, 0, 0, 5'd1, 5'd2));

    idle();
    in_valid = 1'b1; in_alu_op = 2'b00; in_alu_src = 1'b1;
    in_imm = 8'hFE; in_rt_addr = 5'd7; in_reg_dst = 1'b0;
    in_rd_addr = 5'd9; in_rs_addr = 5'd4; in_rs_data = 8'h10;
    in_rt_data = 8'h33; in_reg_write = 1'b1; in_mem_read = 1'b1;
    in_mem_to_reg = 1'b1;
    cyc("itype_load", mk(8'h10, 8'hFE, 4'h2, 8'h33, 5'd7,
                         1, 1, 1, 0, 1, 5'd4, 5'd7));

    for (int i = 0; i < 7; i++) begin
      idle();
      in_valid = 1'b1; in_alu_op = t_op[i]; in_funct = t_fn[i];
      in_rs_data = 8'(8'h40 + i); in_rt_data = 8'(8'h80 + i);
      in_rs_addr = 5'd1; in_rt_addr = 5'd2; in_rd_addr = 5'd3;
      in_reg_dst = 1'b1; in_reg_write = 1'b1;
      cyc("decode_table", mk(8'(8'h40 + i), 8'(8'h80 + i), t_sel[i],
                             8'(8'h80 + i), 5'd3, 1, 1, 0, 0, 0,
                             5'd1, 5'd2));
    end

    idle();
    in_valid = 1'b1; in_alu_op = 2'b00; in_alu_src = 1'b1;
    in_imm = 8'h04; in_rs_data = 8'h20; in_rt_data = 8'hAB;
    in_rs_addr = 5'd2; in_rt_addr = 5'd3; in_mem_write = 1'b1;
    cyc("store", mk(8'h20, 8'h04, 4'h2, 8'hAB, 5'd3,
                    1, 0, 0, 1, 0, 5'd2, 5'd3));

    for (int i = 0; i < 3; i++) begin
      rand_in(); flush = 1'b0; stall = 1'b1;
      cyc("stall_hold", mk(8'h20, 8'h04, 4'h2, 8'hAB, 5'd3,
                           1, 0, 0, 1, 0, 5'd2, 5'd3));
    end

    rand_in(); stall = 1'b1; flush = 1'b1;
    cyc("stall_flush", '0);

    rtype_sub();
    cyc("reload", mk(8'h09, 8'h04, 4'h6, 8'h04, 5'd3,
                     1, 1, 0, 0, 0, 5'd1, 5'd2));
    rtype_sub(); in_valid = 1'b0;
    cyc("invalid_bubble", '0);

    rtype_sub(); in_rd_addr = 5'd0;
    cyc("r0_rd", mk(8'h09, 8'h04, 4'h6, 8'h04, 5'd0,
                    1, 0, 0, 0, 0, 5'd1, 5'd2));
    rtype_sub(); in_reg_dst = 1'b0; in_rt_addr = 5'd0;
    cyc("r0_rt", mk(8'h09, 8'h04, 4'h6, 8'h04, 5'd0,
                    1, 0, 0, 0, 0, 5'd1, 5'd0));

    rtype_sub();
    cyc("pre_reset", mk(8'h09, 8'h04, 4'h6, 8'h04, 5'd3,
                        1, 1, 0, 0, 0, 5'd1, 5'd2));
    rtype_sub(); rst = 1'b0; stall = 1'b1;
    cyc("reset_over_stall", '0);

`ifdef ID_EX_FORWARDING_EN
    idle();
    in_valid = 1'b1; in_alu_op = 2'b00; in_rs_addr = 5'd5;
    in_rt_addr = 5'd6; in_rs_data = 8'h01; in_rt_data = 8'h02;
    in_imm = 8'h77; in_reg_write = 1'b1;
    exmem_reg_write = 1'b1; exmem_wr_addr = 5'd5; exmem_result = 8'h11;
    memwb_reg_write = 1'b1; memwb_wr_addr = 5'd5; memwb_result = 8'h22;
    cyc("fwd_exmem", mk(8'h11, 8'h02, 4'h2, 8'h02, 5'd6,
                        1, 1, 0, 0, 0, 5'd5, 5'd6));
    stall = 1'b1; exmem_reg_write = 1'b0;
    cyc("fwd_memwb", mk(8'h22, 8'h02, 4'h2, 8'h02, 5'd6,
                        1, 1, 0, 0, 0, 5'd5, 5'd6));
    exmem_reg_write = 1'b1; exmem_wr_addr = 5'd0;
    cyc("fwd_exmem_r0", mk(8'h22, 8'h02, 4'h2, 8'h02, 5'd6,
                           1, 1, 0, 0, 0, 5'd5, 5'd6));
    memwb_wr_addr = 5'd0;
    cyc("fwd_none", mk(8'h01, 8'h02, 4'h2, 8'h02, 5'd6,
                       1, 1, 0, 0, 0, 5'd5, 5'd6));
    exmem_wr_addr = 5'd6; exmem_result = 8'h33;
    memwb_wr_addr = 5'd6; memwb_result = 8'h44;
    cyc("fwd_rt", mk(8'h01, 8'h33, 4'h2, 8'h33, 5'd6,
                     1, 1, 0, 0, 0, 5'd5, 5'd6));
`endif

    idle();
    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
